// File: rtl/riscv_muldiv_pkg.sv
// rtl/riscv_muldiv_pkg.sv - shared encodings for the RV32M multiply/divide sequencer
package riscv_muldiv_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Multiply: {hi, lo} with the multiplier in lo, consumed LSB first.
  assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
  // Divide: {rem, quo}; the dividend shifts out of quo into rem as quotient bits shift in.
  assign rem_sh = acc[2*XLEN-1:XLEN-1];
  assign diff   = rem_sh - {1'b0, operand};

  always_comb begin
    acc_next = {sum, acc[XLEN-1:1]};
    if (is_div) begin
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq_unit.sv
// rtl/muldiv_seq_unit.sv - iterative RV32M multiply/divide sequencer beside the EX ALU
module muldiv_seq_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   b_mag_q;
  logic [XLEN-1:0]   result_q;
  logic              neg_res_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_step;

  logic              sgn_a, sgn_b, neg_res_d;
  logic              div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc_init, prod;
  logic [XLEN-1:0]   quo, rem, fix_val;

  assign sgn_a = op_a[XLEN-1] & (funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
  assign sgn_b = op_b[XLEN-1] & (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
  assign a_mag = sgn_a ? -op_a : op_a;
  assign b_mag = sgn_b ? -op_b : op_b;
  assign neg_res_d = (funct3 == F3_REM) ? sgn_a : (sgn_a ^ sgn_b);

  assign div_zero = funct3[2] & (op_b == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (op_a == SMIN) && (op_b == '1);
  assign special  = div_zero | div_ovf;
  assign accept   = (state_q == IDLE) & start & ~flush;

  // Special cases preload {rem, quo} with the architectural answer and take only the FIX cycle.
  always_comb begin
    acc_init = {{XLEN{1'b0}}, a_mag};
    if (div_zero) begin
      acc_init = {op_a, {XLEN{1'b1}}};
    end else if (div_ovf) begin
      acc_init = {{XLEN{1'b0}}, SMIN};
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc      (acc_q),
    .operand  (b_mag_q),
    .is_div   (f3_q[2]),
    .acc_next (acc_step)
  );

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem  = neg_res_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_val = prod[2*XLEN-1:XLEN];
    case (f3_q)
      F3_MUL:           fix_val = prod[XLEN-1:0];
      F3_DIV, F3_DIVU:  fix_val = quo;
      F3_REM, F3_REMU:  fix_val = rem;
      default:          fix_val = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? FIX : CALC;
      CALC: if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      f3_q      <= '0;
      b_mag_q   <= '0;
      neg_res_q <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      f3_q      <= funct3;
      b_mag_q   <= b_mag;
      neg_res_q <= neg_res_d & ~special;
      acc_q     <= acc_init;
    end else if (!flush && state_q == CALC) begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= acc_step;
    end else if (!flush && state_q == FIX) begin
      result_q <= fix_val;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign stall  = start & ~done;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// tb/tb_muldiv_seq_unit.sv - scoreboard bench for muldiv_seq_unit against an arithmetic model
module tb_muldiv_seq_unit;
  import riscv_muldiv_pkg::*;

  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, stall;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] last_exp = '0;

  typedef struct {
    logic [31:0] res;
    int          accept;
    int          lat;
  } exp_t;
  exp_t scb[$];

  muldiv_seq_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'b0, b});
    case (f)
      F3_MUL:    begin p = sa * sbv; return p[31:0]; end
      F3_MULH:   begin p = sa * sbv; return p[63:32]; end
      F3_MULHSU: begin p = sa * ub;  return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == SMIN && b == 32'hFFFF_FFFF) return SMIN;
        return 32'(sa / sbv);
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == SMIN && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sbv);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == F3_DIV || f == F3_REM) && a == SMIN && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Monitor: every done pulse retires the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with empty scoreboard, expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = scb.pop_front();
        check("result", result, e.res);
        check("latency", 32'(cyc - e.accept), 32'(e.lat));
      end
    end
  end

  // Called on a negedge with the unit idle or in its done cycle; returns on the done negedge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    int st;
    e.accept = done ? cyc + 2 : cyc + 1;
    e.res    = ref_op(f, a, b);
    e.lat    = exp_lat(f, a, b);
    scb.push_back(e);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    n = 0; st = 0;
    do begin
      @(negedge clk);
      n++;
      if (cyc >= e.accept) begin
        if (stall && !done) st++;
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
      end
    end while (!done && n < 200);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done after %0d", n, e.lat);
    end else begin
      check("stall_at_done", {31'b0, stall}, 32'h0);
      check("stall_cycles", 32'(st), 32'(e.lat));
      last_exp = e.res;
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int nd;

    repeat (3) @(negedge clk);
    check("reset_busy",   {31'b0, busy},  32'h0);
    check("reset_done",   {31'b0, done},  32'h0);
    check("reset_stall",  {31'b0, stall}, 32'h0);
    check("reset_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(F3_MUL,    32'd7,         32'hFFFF_FFFD);
    check("mul_neg_value", last_exp, 32'hFFFF_FFEB);
    @(negedge clk);
    run_op(F3_MULH,   SMIN,          SMIN);
    run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F3_DIV,    32'hFFFF_FFF9, 32'd2);
    run_op(F3_REM,    32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    run_op(F3_DIVU,   32'd100,       32'd7);
    run_op(F3_REMU,   32'd100,       32'd7);
    run_op(F3_DIVU,   32'd5,         32'd0);
    @(negedge clk);
    run_op(F3_REM,    32'd5,         32'd0);
    run_op(F3_DIV,    SMIN,          32'hFFFF_FFFF);
    run_op(F3_REM,    SMIN,          32'hFFFF_FFFF);

    // Flush mid-calculation: no done, result untouched, next op clean.
    @(negedge clk);
    start = 1'b1; funct3 = F3_MUL; op_a = $urandom; op_b = $urandom;
    repeat (11) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy",   {31'b0, busy}, 32'h0);
    check("flush_result", result, last_exp);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("flush_no_done", 32'(nd), 32'h0);
    run_op(F3_MUL, 32'd3, 32'd4);

    // Asynchronous reset mid-calculation, start held through it.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIV; op_a = $urandom; op_b = 32'd3;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy",   {31'b0, busy}, 32'h0);
    check("rst_done",   {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);

    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(7))
        0: b = 32'h0;
        1: begin a = SMIN; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(15));
        default: ;
      endcase
      if ($urandom_range(1) == 1) @(negedge clk);
      run_op(f, a, b);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(scb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
